// File: rtl/exec_pkg.sv
// Shared constants for the execute stage: operation codes, forwarding selects, FSM states.
package exec_pkg;

   localparam int unsigned OP_ADD = 0;
   localparam int unsigned OP_SUB = 1;
   localparam int unsigned OP_AND = 2;
   localparam int unsigned OP_OR  = 3;
   localparam int unsigned OP_XOR = 4;
   localparam int unsigned OP_SLL = 5;
   localparam int unsigned OP_SRL = 6;
   localparam int unsigned OP_SRA = 7;
   localparam int unsigned OP_SLT = 8;
   localparam int unsigned OP_MUL = 9;

   localparam logic [1:0] FWD_DEC = 2'd0;
   localparam logic [1:0] FWD_MEM = 2'd1;
   localparam logic [1:0] FWD_WB  = 2'd2;

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } state_t;

endpackage

// File: rtl/exec_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low DATA_W product bits.
module exec_mul_iter #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = $clog2(DATA_W)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              done_c,
   output logic [DATA_W-1:0] product_c
);

   logic [DATA_W-1:0] mcand_q;
   logic [DATA_W-1:0] mplier_q;
   logic [DATA_W-1:0] acc_q;
   logic [CNT_W-1:0]  count_q;
   logic              active_q;
   logic [DATA_W-1:0] partial_c;

   // Accumulator value after the current iteration; on the last one it is the product.
   always_comb begin
      partial_c = acc_q + (mplier_q[0] ? mcand_q : '0);
      product_c = partial_c;
      done_c    = active_q && (count_q == CNT_W'(DATA_W - 1));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         count_q  <= '0;
         active_q <= 1'b0;
      end else if (start) begin
         mcand_q  <= a;
         mplier_q <= b;
         acc_q    <= '0;
         count_q  <= '0;
         active_q <= 1'b1;
      end else if (active_q) begin
         acc_q    <= partial_c;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         count_q  <= count_q + CNT_W'(1);
         if (done_c) active_q <= 1'b0;
      end
   end

endmodule

// File: rtl/execute_stage_mc.sv
// Execute stage with operand forwarding, registered EX/MEM handshake and an
// iterative multiplier that holds off decode while it runs.
import exec_pkg::*;

module execute_stage_mc #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned OP_W   = 4,
   parameter int unsigned SH_W   = $clog2(DATA_W)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   operation,
   input  logic [DATA_W-1:0] reg1,
   input  logic [DATA_W-1:0] reg2,
   input  logic [DATA_W-1:0] st_in,
   input  logic [1:0]        reg1_sel,
   input  logic [1:0]        reg2_sel,
   input  logic [1:0]        st_sel,
   input  logic [DATA_W-1:0] mem_result,
   input  logic [DATA_W-1:0] wb_result,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] alu_result,
   output logic [DATA_W-1:0] st_out,
   output logic              busy
);

   state_t            state_q, state_d;
   logic              out_valid_d;
   logic [DATA_W-1:0] alu_result_d;
   logic [DATA_W-1:0] st_out_d;
   logic [DATA_W-1:0] st_hold_q, st_hold_d;

   logic [DATA_W-1:0] op_a_c, op_b_c, st_fwd_c, alu_c;
   logic [SH_W-1:0]   sh_c;
   logic              accept_c, is_mul_c, mul_start_c, mul_done_c;
   logic [DATA_W-1:0] mul_product_c;

   function automatic logic [DATA_W-1:0] fwd_mux(input logic [1:0] sel,
                                                 input logic [DATA_W-1:0] dec,
                                                 input logic [DATA_W-1:0] mem,
                                                 input logic [DATA_W-1:0] wb);
      case (sel)
         FWD_MEM: fwd_mux = mem;
         FWD_WB:  fwd_mux = wb;
         default: fwd_mux = dec;
      endcase
   endfunction

   always_comb begin
      op_a_c   = fwd_mux(reg1_sel, reg1, mem_result, wb_result);
      op_b_c   = fwd_mux(reg2_sel, reg2, mem_result, wb_result);
      st_fwd_c = fwd_mux(st_sel, st_in, mem_result, wb_result);
      sh_c     = op_b_c[SH_W-1:0];
      in_ready = (state_q == IDLE) && (!out_valid || out_ready);
      accept_c = in_valid && in_ready;
      is_mul_c = (operation == OP_W'(OP_MUL));
   end

   // Single-cycle ALU; undefined codes (and MUL, handled elsewhere) yield zero.
   always_comb begin
      alu_c = '0;
      case (operation)
         OP_W'(OP_ADD): alu_c = op_a_c + op_b_c;
         OP_W'(OP_SUB): alu_c = op_a_c - op_b_c;
         OP_W'(OP_AND): alu_c = op_a_c & op_b_c;
         OP_W'(OP_OR):  alu_c = op_a_c | op_b_c;
         OP_W'(OP_XOR): alu_c = op_a_c ^ op_b_c;
         OP_W'(OP_SLL): alu_c = op_a_c << sh_c;
         OP_W'(OP_SRL): alu_c = op_a_c >> sh_c;
         OP_W'(OP_SRA): alu_c = $unsigned($signed(op_a_c) >>> sh_c);
         OP_W'(OP_SLT): alu_c = ($signed(op_a_c) < $signed(op_b_c)) ? DATA_W'(1) : '0;
         default:       alu_c = '0;
      endcase
   end

   exec_mul_iter #(
      .DATA_W (DATA_W)
   ) u_mul (
      .clk       (clk),
      .rst       (rst),
      .start     (mul_start_c),
      .a         (op_a_c),
      .b         (op_b_c),
      .done_c    (mul_done_c),
      .product_c (mul_product_c)
   );

   // Next-state and output-register logic.
   always_comb begin
      state_d      = state_q;
      out_valid_d  = out_valid;
      alu_result_d = alu_result;
      st_out_d     = st_out;
      st_hold_d    = st_hold_q;
      mul_start_c  = 1'b0;

      if (out_valid && out_ready) out_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept_c) begin
               if (is_mul_c) begin
                  state_d     = MUL;
                  mul_start_c = 1'b1;
                  st_hold_d   = st_fwd_c;
               end else begin
                  alu_result_d = alu_c;
                  st_out_d     = st_fwd_c;
                  out_valid_d  = 1'b1;
               end
            end
         end
         MUL: begin
            if (mul_done_c) begin
               alu_result_d = mul_product_c;
               st_out_d     = st_hold_q;
               out_valid_d  = 1'b1;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         out_valid  <= 1'b0;
         alu_result <= '0;
         st_out     <= '0;
         st_hold_q  <= '0;
         busy       <= 1'b0;
      end else begin
         state_q    <= state_d;
         out_valid  <= out_valid_d;
         alu_result <= alu_result_d;
         st_out     <= st_out_d;
         st_hold_q  <= st_hold_d;
         busy       <= (state_d == MUL);
      end
   end

endmodule

// File: tb/tb_execute_stage_mc.sv
// Scoreboard bench for execute_stage_mc: expected results queued at issue, compared at retire.
import exec_pkg::*;

module tb_execute_stage_mc;

   logic        clk, rst;
   logic        in_valid, in_ready;
   logic [3:0]  operation;
   logic [31:0] reg1, reg2, st_in, mem_result, wb_result;
   logic [1:0]  reg1_sel, reg2_sel, st_sel;
   logic        out_valid, out_ready, busy;
   logic [31:0] alu_result, st_out;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_alu_q[$];
   logic [31:0] exp_st_q[$];
   logic [31:0] sb_alu, sb_st;

   execute_stage_mc dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .operation  (operation),
      .reg1       (reg1),
      .reg2       (reg2),
      .st_in      (st_in),
      .reg1_sel   (reg1_sel),
      .reg2_sel   (reg2_sel),
      .st_sel     (st_sel),
      .mem_result (mem_result),
      .wb_result  (wb_result),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .alu_result (alu_result),
      .st_out     (st_out),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] dec,
                                       input logic [31:0] mem, input logic [31:0] wb);
      if (sel == 2'd1) return mem;
      if (sel == 2'd2) return wb;
      return dec;
   endfunction

   function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      logic signed [31:0] sa, sb;
      sa = a;
      sb = b;
      case (op)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a & b;
         4'd3: return a | b;
         4'd4: return a ^ b;
         4'd5: return a << b[4:0];
         4'd6: return a >> b[4:0];
         4'd7: return sa >>> b[4:0];
         4'd8: return (sa < sb) ? 32'd1 : 32'd0;
         4'd9: return a * b;
         default: return 32'd0;
      endcase
   endfunction

   // Called just after a rising edge; returns just after the accept edge.
   task automatic issue(input logic [3:0] op, input logic [31:0] r1, input logic [1:0] s1,
                        input logic [31:0] r2, input logic [1:0] s2,
                        input logic [31:0] st, input logic [1:0] ss,
                        input logic [31:0] mem, input logic [31:0] wb);
      int n;
      n = 0;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) check_val("in_ready_timeout", 32'd0, 32'd1);
      operation  = op;
      reg1       = r1;
      reg2       = r2;
      st_in      = st;
      reg1_sel   = s1;
      reg2_sel   = s2;
      st_sel     = ss;
      mem_result = mem;
      wb_result  = wb;
      in_valid   = 1'b1;
      exp_alu_q.push_back(model(op, fwd(s1, r1, mem, wb), fwd(s2, r2, mem, wb)));
      exp_st_q.push_back(fwd(ss, st, mem, wb));
      @(posedge clk); #1;
      in_valid   = 1'b0;
      reg1       = $urandom;
      reg2       = $urandom;
      st_in      = $urandom;
      mem_result = $urandom;
      wb_result  = $urandom;
   endtask

   task automatic wait_valid(output int n);
      n = 1;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   // Retire monitor: inputs change just after rising edges, so sample on the falling edge.
   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         if (exp_alu_q.size() == 0) begin
            check_val("unexpected_result", alu_result, 32'hxxxx_xxxx);
         end else begin
            sb_alu = exp_alu_q.pop_front();
            sb_st  = exp_st_q.pop_front();
            check_val("sb_alu", alu_result, sb_alu);
            check_val("sb_st", st_out, sb_st);
         end
      end
   end

   initial begin
      int n, busy_cnt, seen;
      logic [3:0] rop;

      rst = 1'b0; in_valid = 1'b0; operation = '0; reg1 = '0; reg2 = '0; st_in = '0;
      reg1_sel = '0; reg2_sel = '0; st_sel = '0; mem_result = '0; wb_result = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_out_valid", 32'(out_valid), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_alu", alu_result, 32'd0);
      check_val("rst_st", st_out, 32'd0);
      check_val("rst_in_ready", 32'(in_ready), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;

      // ADD with operand 1 forwarded from MEM
      issue(4'(OP_ADD), 32'd99, 2'd1, 32'd7, 2'd0, 32'd0, 2'd0, 32'd5, 32'd0);
      check_val("add_valid", 32'(out_valid), 32'd1);
      check_val("add_alu", alu_result, 32'd12);

      issue(4'(OP_SUB), 32'd0, 2'd0, 32'd1, 2'd0, 32'd0, 2'd0, 32'd0, 32'd0);
      check_val("sub_alu", alu_result, 32'hFFFF_FFFF);
      issue(4'(OP_SRA), 32'h8000_0000, 2'd0, 32'd4, 2'd0, 32'd0, 2'd0, 32'd0, 32'd0);
      check_val("sra_alu", alu_result, 32'hF800_0000);

      // MUL with operand 2 forwarded from WB; latency and stall window
      issue(4'(OP_MUL), 32'd7, 2'd0, 32'd0, 2'd2, 32'h11, 2'd0, 32'd0, 32'd6);
      busy_cnt = 0;
      n = 1;
      while (!out_valid && n < 100) begin
         if (busy && !in_ready) busy_cnt++;
         @(posedge clk); #1;
         n++;
      end
      check_val("mul_latency", 32'(n), 32'd33);
      check_val("mul_busy_cycles", 32'(busy_cnt), 32'd32);
      check_val("mul_busy_done", 32'(busy), 32'd0);
      check_val("mul_alu", alu_result, 32'd42);
      check_val("mul_st", st_out, 32'h11);
      @(posedge clk); #1;

      issue(4'(OP_MUL), 32'hFFFF_FFFF, 2'd0, 32'd2, 2'd0, 32'd0, 2'd0, 32'd0, 32'd0);
      wait_valid(n);
      check_val("mul_wrap", alu_result, 32'hFFFF_FFFE);
      @(posedge clk); #1;

      // Backpressure holds the OR result, then retire and accept in the same cycle
      out_ready = 1'b0;
      issue(4'(OP_OR), 32'h0F, 2'd0, 32'hF0, 2'd0, 32'd0, 2'd0, 32'd0, 32'd0);
      repeat (4) begin
         @(posedge clk); #1;
         check_val("bp_alu_hold", alu_result, 32'hFF);
         check_val("bp_valid_hold", 32'(out_valid), 32'd1);
         check_val("bp_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      issue(4'(OP_ADD), 32'd1, 2'd0, 32'd1, 2'd0, 32'd0, 2'd0, 32'd0, 32'd0);
      check_val("bp_next_alu", alu_result, 32'd2);
      check_val("bp_next_valid", 32'(out_valid), 32'd1);

      // Reset in the middle of a MUL
      issue(4'(OP_MUL), 32'd3, 2'd0, 32'd5, 2'd0, 32'd0, 2'd0, 32'd0, 32'd0);
      repeat (9) begin
         @(posedge clk); #1;
      end
      rst = 1'b0;
      #1;
      exp_alu_q.delete();
      exp_st_q.delete();
      check_val("midrst_valid", 32'(out_valid), 32'd0);
      check_val("midrst_busy", 32'(busy), 32'd0);
      check_val("midrst_alu", alu_result, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_val("midrst_in_ready", 32'(in_ready), 32'd1);
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid || busy) seen++;
      end
      check_val("midrst_no_stale", 32'(seen), 32'd0);

      // Store-data forwarding
      issue(4'(OP_XOR), 32'd1, 2'd0, 32'd2, 2'd0, 32'hA5, 2'd3, 32'h77, 32'h88);
      check_val("st_sel3", st_out, 32'hA5);
      issue(4'(OP_AND), 32'd1, 2'd0, 32'd2, 2'd0, 32'hA5, 2'd1, 32'h3C, 32'h88);
      check_val("st_sel1", st_out, 32'h3C);

      // Random mix including undefined opcodes and all selects
      for (int i = 0; i < 24; i++) begin
         rop = 4'($urandom_range(0, 11));
         issue(rop, $urandom, 2'($urandom_range(0, 3)), $urandom, 2'($urandom_range(0, 3)),
               $urandom, 2'($urandom_range(0, 3)), $urandom, $urandom);
      end

      n = 0;
      while (exp_alu_q.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check_val("drain_empty", 32'(exp_alu_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/execute_stage_mc.md
Name: execute_stage_mc

Overview:
Parametrised execute stage for the 5-stage pipeline. It adds to the single-cycle execute path:
- a registered EX/MEM output with valid/ready handshake;
- forwarding selection for both ALU operands and the store value;
- an iterative multi-cycle multiplier that stalls upstream while busy.

It sits between decode and memory and replaces the purely combinational execute path.

Parameters:
DATA_W, 32, datapath width (≥8, power of two)
OP_W, 4, operation code width
SH_W, $clog2(DATA_W), shift-amount bits taken from operand 2

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
in_valid  in  1  decode presents an operation
in_ready  out  1  stage can accept this cycle
operation  in  OP_W  operation code (exec_pkg encoding)
reg1  in  DATA_W  operand 1 from decode
reg2  in  DATA_W  operand 2 from decode
st_in  in  DATA_W  store data from decode
reg1_sel  in  2  forwarding select for operand 1
reg2_sel  in  2  forwarding select for operand 2
st_sel  in  2  forwarding select for store data
mem_result  in  DATA_W  forwarded value from MEM stage
wb_result  in  DATA_W  forwarded value from WB stage
out_valid  out  1  registered result valid
out_ready  in  1  MEM stage accepts result
alu_result  out  DATA_W  registered result
st_out  out  DATA_W  registered store data
busy  out  1  multiplier iterating

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; out_valid=0; alu_result=0; st_out=0; busy=0; multiplier registers cleared.
- Forwarding select, applied per operand:
  - 0: decode value
  - 1: mem_result
  - 2: wb_result
  - 3: decode value (reserved)
- Forwarded values are sampled only on the accept cycle.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This is combinational; no in_valid→in_ready path.
- Accept = in_valid && in_ready.
- Single-cycle ops: result and forwarded st value are registered at accept; out_valid=1 on the next edge (latency 1).
- MUL:
  - At accept, capture operands and forwarded st value; state IDLE→MUL; busy=1.
  - Shift-add runs 1 bit/cycle for DATA_W cycles.
  - On the final iteration, load the low DATA_W bits of the product into alu_result and set out_valid; state→IDLE, busy=0.
  - Accept→out_valid latency is DATA_W+1 edges.
- Output hold: while out_valid && !out_ready, alu_result, st_out and out_valid hold. No accept occurs because in_ready=0.
- Output retire: out_valid && out_ready with no new accept gives out_valid=0 next edge. Retire plus accept in the same cycle keeps out_valid=1 with new data.
- MUL completion under backpressure: a MUL finishing while the previous result is still unretired is impossible, since accept required the output slot free or retiring.
- Arithmetic:
  - ADD, SUB and MUL wrap modulo 2^DATA_W.
  - Shifts use reg2[SH_W-1:0].
  - SRA sign-extends.
  - SLT is a signed compare producing 1 or 0.
  - Undefined opcodes produce 0 and complete in one cycle.
- Reset mid-MUL: abort immediately; no result is emitted after reset releases.
- in_valid while busy: ignored (in_ready=0); decode holds its inputs.

Decomposition:
- exec_pkg holds:
  - operation localparams: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, MUL=9;
  - forwarding select constants FWD_DEC=0, FWD_MEM=1, FWD_WB=2;
  - state enum IDLE/MUL.
- One sub-module, exec_mul_iter, holds the iterative multiplier: start, operands, done, product, counter.
- The combinational ALU and forwarding muxes stay in the top level.

Test Plan:
- ADD, reg1_sel=1, mem_result=5, reg2=7, out_ready=1 → one edge after accept, alu_result=12, out_valid=1.
- SUB with reg1=0, reg2=1 → alu_result=0xFFFFFFFF. SRA with reg1=0x80000000, reg2=4 → alu_result=0xF8000000.
- MUL with reg1=7, reg2_sel=2, wb_result=6 → busy=1 and in_ready=0 for 32 cycles; out_valid rises 33 edges after accept; alu_result=42. Also 0xFFFFFFFF*2 → 0xFFFFFFFE.
- Backpressure: OR result (0x0F | 0xF0) with out_ready=0 for 4 cycles → alu_result=0xFF holds and in_ready=0. Then out_ready=1 with a queued ADD 1+1 → next edge alu_result=2 and out_valid stays 1.
- Reset: assert rst=0 at cycle 10 of a MUL → out_valid=0, busy=0, alu_result=0 immediately; after release, in_ready=1 and no stale result appears.
- st_sel=3 with st_in=0xA5 → st_out=0xA5. st_sel=1 with mem_result=0x3C → st_out=0x3C.
